ws2812_axil_slave: RTL and testbench



---
 rtl/ws2812_axil_slave.sv | 210 +++++++++++++++++++++
 tb/tb_ws2812_axil_slave.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_axil_slave.sv
// AXI4-Lite register slave for the WS2812 matrix: CTRL/STATUS registers,
// a GRB pixel buffer with a second synchronous read port for the serial
// transmitter, and the transmitter start pulse.
module ws2812_axil_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 9,
    parameter int unsigned C_NUM_PIXELS       = 64
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [5:0]                      px_addr,
    output logic [23:0]                     px_data,
    input  logic                            tx_busy,
    output logic                            tx_start,
    output logic [7:0]                      tx_len
);

    localparam int unsigned AW     = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
    localparam int unsigned PIX_AW = $clog2(C_NUM_PIXELS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {SEL_NONE, SEL_CTRL, SEL_STATUS, SEL_PIXEL} sel_t;
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic     w_fire, r_fire;

    logic [7:0]        ctrl_len;
    logic [1:0]        busy_sync;
    logic [23:0]       pix_mem [C_NUM_PIXELS];

    sel_t              w_sel, r_sel;
    logic [PIX_AW-1:0] w_idx, r_idx;

    // Map a byte address onto a register select; byte lanes addr[1:0] are ignored.
    function automatic sel_t decode(input logic [AW-1:0] a);
        logic [6:0] pix_hi;
        sel_t       s;
        pix_hi = 7'({1'b0, a[7:2]} >> PIX_AW);
        s = SEL_NONE;
        if (a[8:2] == 7'd0)
            s = SEL_CTRL;
        else if (a[8:2] == 7'd1)
            s = SEL_STATUS;
        else if (a[8] && (pix_hi == 7'd0))
            s = SEL_PIXEL;
        return s;
    endfunction

    assign w_sel  = decode(S_AXI_AWADDR);
    assign r_sel  = decode(S_AXI_ARADDR);
    assign w_idx  = S_AXI_AWADDR[2 +: PIX_AW];
    assign r_idx  = S_AXI_ARADDR[2 +: PIX_AW];
    assign tx_len = ctrl_len;

    // Write FSM state register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)
            w_state <= W_IDLE;
        else
            w_state <= w_next;
    end

    // Write FSM: AW and W are only ever accepted together, then hold B until taken.
    always_comb begin
        w_next        = w_state;
        w_fire        = 1'b0;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    S_AXI_AWREADY = 1'b1;
                    S_AXI_WREADY  = 1'b1;
                    w_fire        = 1'b1;
                    w_next        = W_RESP;
                end
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY)
                    w_next = W_IDLE;
            end
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)
            r_state <= R_IDLE;
        else
            r_state <= r_next;
    end

    // Read FSM: one-cycle ARREADY in idle, then hold R until taken.
    always_comb begin
        r_next        = r_state;
        r_fire        = 1'b0;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    S_AXI_ARREADY = 1'b1;
                    r_fire        = 1'b1;
                    r_next        = R_DATA;
                end
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY)
                    r_next = R_IDLE;
            end
        endcase
    end

    // Register-side write commit: CTRL.LEN, START pulse and write response.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_len    <= 8'd0;
            tx_start    <= 1'b0;
            S_AXI_BRESP <= RESP_OKAY;
        end else begin
            tx_start <= 1'b0;
            if (w_fire) begin
                S_AXI_BRESP <= (w_sel == SEL_CTRL || w_sel == SEL_PIXEL) ? RESP_OKAY : RESP_SLVERR;
                if (w_sel == SEL_CTRL) begin
                    if (S_AXI_WSTRB[1])
                        ctrl_len <= S_AXI_WDATA[15:8];
                    tx_start <= S_AXI_WSTRB[0] & S_AXI_WDATA[0];
                end
            end
        end
    end

    // Pixel buffer byte-lane writes; the RAM itself has no reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_fire && w_sel == SEL_PIXEL) begin
            for (int b = 0; b < 3; b++) begin
                if (S_AXI_WSTRB[b])
                    pix_mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    // Transmitter read port, one cycle of latency.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)
            px_data <= 24'd0;
        else
            px_data <= pix_mem[px_addr[PIX_AW-1:0]];
    end

    // Two-flop synchroniser for the transmitter busy flag.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)
            busy_sync <= 2'b00;
        else
            busy_sync <= {busy_sync[0], tx_busy};
    end

    // Capture read data at the AR handshake; a same-edge write is not yet visible.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= RESP_OKAY;
        end else if (r_fire) begin
            S_AXI_RRESP <= RESP_OKAY;
            case (r_sel)
                SEL_CTRL:   S_AXI_RDATA <= DW'({16'd0, ctrl_len, 8'd0});
                SEL_STATUS: S_AXI_RDATA <= DW'({31'd0, busy_sync[1]});
                SEL_PIXEL:  S_AXI_RDATA <= DW'({8'd0, pix_mem[r_idx]});
                default: begin
                    S_AXI_RDATA <= '0;
                    S_AXI_RRESP <= RESP_SLVERR;
                end
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         S_AXI_WDATA[31:24], S_AXI_WSTRB[3], px_addr};

endmodule

// File: tb/tb_ws2812_axil_slave.sv
// Directed bench for ws2812_axil_slave: register map, strobes, handshakes,
// START pulse, pixel port and asynchronous reset.
module tb_ws2812_axil_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [8:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [5:0]  px_addr = '0;
    logic [23:0] px_data;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_len;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;

    ws2812_axil_slave dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .px_addr       (px_addr),
        .px_data       (px_data),
        .tx_busy       (tx_busy),
        .tx_start      (tx_start),
        .tx_len        (tx_len)
    );

    always #5 clk = ~clk;

    // Count cycles in which tx_start is high.
    always @(negedge clk) if (tx_start) start_cnt <= start_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        #1;
        n = 0;
        while (!(awready && wready) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("wr_handshake", 32'(n < 20), 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        #1;
        chk("wr_bvalid", 32'(bvalid), 32'd1);
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [8:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rd_handshake", 32'(n < 20), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        chk("rd_rvalid", 32'(rvalid), 32'd1);
        d = rdata;
        resp = rresp;
        @(negedge clk);
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d, d2;
        logic [1:0]  r, r2;
        int          c0, pulses, held;

        // Reset and idle
        repeat (2) @(negedge clk);
        #1;
        chk("rst_px_data", 32'(px_data), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("idle_ready_valid", 32'({awready, wready, bvalid, arready, rvalid}), 32'd0);
        chk("idle_tx_len", 32'(tx_len), 32'd0);
        axi_read(9'h000, d, r);
        chk("ctrl_rst_data", d, 32'h0000_0000);
        chk("ctrl_rst_resp", 32'(r), 32'd0);

        // Pixel write with full then partial strobes
        axi_write(9'h114, 32'hAABB_CCDD, 4'hF, r);
        chk("pix_wr1_resp", 32'(r), 32'd0);
        axi_write(9'h114, 32'h1122_3344, 4'h2, r);
        chk("pix_wr2_resp", 32'(r), 32'd0);
        axi_read(9'h114, d, r);
        chk("pix5_data", d, 32'h00BB_33DD);
        chk("pix5_resp", 32'(r), 32'd0);
        axi_read(9'h116, d, r);
        chk("pix5_lowbits_ignored", d, 32'h00BB_33DD);
        @(negedge clk);
        px_addr = 6'd5;
        @(negedge clk);
        chk("px_port", 32'(px_data), 32'h00BB_33DD);

        // STATUS write: AW early, W later, BREADY held low
        @(negedge clk);
        awaddr = 9'h004; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; awvalid = 1'b1; bready = 1'b0;
        #1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (awready || wready) pulses++;
            @(negedge clk); #1;
        end
        chk("lone_aw_waits", 32'(pulses), 32'd0);
        wvalid = 1'b1;
        #1;
        pulses = 0; held = 0;
        for (int i = 0; i < 6; i++) begin
            if (awready && wready) pulses++;
            if (awready != wready) pulses += 10;
            if (i > 0 && bvalid && bresp == 2'b10) held++;
            @(negedge clk); #1;
        end
        chk("aw_w_single_pulse", 32'(pulses), 32'd1);
        chk("bvalid_held_slverr", 32'(held), 32'd5);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk); #1;
        chk("bvalid_drop", 32'(bvalid), 32'd0);
        bready = 1'b0;
        axi_write(9'h008, 32'h1234_5678, 4'hF, r);
        chk("unmapped_wr_resp", 32'(r), 32'd2);

        // Unmapped read with RREADY held low
        @(negedge clk);
        araddr = 9'h080; arvalid = 1'b1; rready = 1'b0;
        #1;
        chk("ar_pulse", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        held = 0;
        for (int i = 0; i < 4; i++) begin
            if (rvalid && rdata == 32'd0 && rresp == 2'b10) held++;
            @(negedge clk); #1;
        end
        chk("rd_held_slverr", 32'(held), 32'd4);
        rready = 1'b1;
        @(negedge clk); #1;
        chk("rvalid_drop", 32'(rvalid), 32'd0);
        rready = 1'b0;

        // CTRL write with START
        c0 = start_cnt;
        axi_write(9'h000, 32'h0000_4001, 4'hF, r);
        repeat (3) @(negedge clk);
        chk("start_one_cycle", 32'(start_cnt - c0), 32'd1);
        chk("tx_len_40", 32'(tx_len), 32'h40);
        axi_read(9'h000, d, r);
        chk("ctrl_readback", d, 32'h0000_4000);
        chk("ctrl_resp", 32'(r), 32'd0);
        c0 = start_cnt;
        axi_write(9'h000, 32'h0000_1201, 4'h2, r);
        repeat (3) @(negedge clk);
        chk("start_needs_strb0", 32'(start_cnt - c0), 32'd0);
        chk("tx_len_12", 32'(tx_len), 32'h12);

        // STATUS reflects synchronised tx_busy
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        axi_read(9'h004, d, r);
        chk("status_busy", d, 32'd1);
        chk("status_resp", 32'(r), 32'd0);
        tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        axi_read(9'h004, d, r);
        chk("status_idle", d, 32'd0);

        // Same-cycle write and read to one pixel
        fork
            axi_write(9'h114, 32'h0012_3456, 4'hF, r2);
            axi_read(9'h114, d, r);
        join
        chk("same_cycle_old", d, 32'h00BB_33DD);
        axi_read(9'h114, d2, r);
        chk("same_cycle_new", d2, 32'h0012_3456);

        // Reset while B and R are both pending
        @(negedge clk);
        awaddr = 9'h118; wdata = 32'h00C0_FFEE; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        araddr = 9'h114; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        #1;
        chk("pre_rst_valids", 32'({bvalid, rvalid}), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valids", 32'({bvalid, rvalid}), 32'd0);
        chk("rst_ctrl_len", 32'(tx_len), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        axi_read(9'h118, d, r);
        chk("post_rst_pix6", d, 32'h00C0_FFEE);
        axi_read(9'h000, d, r);
        chk("post_rst_ctrl", d, 32'd0);
        axi_write(9'h13C, 32'h0055_AA11, 4'hF, r);
        chk("post_rst_wr_resp", 32'(r), 32'd0);
        axi_read(9'h13C, d, r);
        chk("post_rst_rd", d, 32'h0055_AA11);
        axi_read(9'h0FC, d, r);
        chk("unmapped_0fc_resp", 32'(r), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
